// File: rtl/inst_mem_pkg.sv
// Shared types and default sizing for the instruction memory and its burst loader.
package inst_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1024;

    typedef enum logic {
        LdIdle,
        LdLoad
    } ldState_e;

endpackage

// File: rtl/inst_mem_array.sv
// Simple dual-port storage: one write port, one registered read port, no reset on contents.
// Define INST_MEM_WR_BYPASS_EN to forward same-cycle write data to a colliding read.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
`ifdef INST_MEM_WR_BYPASS_EN
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
`else
            // Read-before-write: a colliding read sees the old word.
            rdata <= mem[raddr];
`endif
        end
    end

endmodule

// File: rtl/inst_mem_ld.sv
// Instruction memory with a 1-cycle fetch port and a burst loader (IDLE/LOAD FSM).
// Collision behaviour is selected by INST_MEM_WR_BYPASS_EN (see inst_mem_array).
module inst_mem_ld
    import inst_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done
);

    localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   RemOne  = (ADDR_W + 1)'(1);

    ldState_e          stateQ, stateD;
    logic [ADDR_W-1:0] ptrQ, ptrD;
    logic [ADDR_W:0]   remQ, remD;
    logic              doneQ, doneD;

    logic              fetchInRange;
    logic              fetchValidQ, fetchErrQ, fetchZeroQ;
    logic              wrEn;
    logic [DATA_W-1:0] rdData;

    assign fetchInRange = ({1'b0, fetch_addr} < DepthW);
    assign wrEn         = ld_ready && ld_valid;

    inst_mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) uArray (
        .clk  (clk),
        .we   (wrEn),
        .waddr(ptrQ),
        .wdata(ld_data),
        .re   (fetch_en && fetchInRange),
        .raddr(fetch_addr),
        .rdata(rdData)
    );

    // fetchZeroQ masks the array output after reset and error fetches; it holds while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchValidQ <= 1'b0;
            fetchErrQ   <= 1'b0;
            fetchZeroQ  <= 1'b1;
        end else begin
            fetchValidQ <= fetch_en;
            fetchErrQ   <= fetch_en && !fetchInRange;
            if (fetch_en) begin
                fetchZeroQ <= !fetchInRange;
            end
        end
    end

    assign fetch_data  = fetchZeroQ ? '0 : rdData;
    assign fetch_valid = fetchValidQ;
    assign fetch_err   = fetchErrQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= LdIdle;
            ptrQ   <= '0;
            remQ   <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            remQ   <= remD;
            doneQ  <= doneD;
        end
    end

    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        remD   = remQ;
        doneD  = 1'b0;
        unique case (stateQ)
            LdIdle: begin
                if (ld_start && ({1'b0, ld_base} < DepthW)) begin
                    if (ld_len == '0) begin
                        doneD = 1'b1;
                    end else begin
                        ptrD   = ld_base;
                        remD   = ld_len;
                        stateD = LdLoad;
                    end
                end
            end
            LdLoad: begin
                if (ld_valid) begin
                    ptrD = (ptrQ == LastPtr) ? '0 : ptrQ + PtrOne;
                    remD = remQ - RemOne;
                    if (remQ == RemOne) begin
                        stateD = LdIdle;
                        doneD  = 1'b1;
                    end
                end
            end
            default: stateD = LdIdle;
        endcase
    end

    assign ld_ready = (stateQ == LdLoad);
    assign ld_busy  = (stateQ == LdLoad);
    assign ld_done  = doneQ;

endmodule
